// File: rtl/integrator_pkg.sv
// Shared types and default widths for the integrator core and its dump sequencer.
// No logic; latency and backpressure do not apply.
package integrator_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int ACC_W_DEF = 16;
    localparam int CNT_W_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_STRB   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DUMP   = 3'd5
    } state_t;

endpackage

// File: rtl/integrator_dump_ctrl.sv
// Integrate-and-dump sequencer: one strobe per accepted sample, dumps the core every win_len samples; INTEGRATOR_DUMP_SEQ_EN adds dump_seq.
// First s_ready 2 cycles after start, dump_valid 3 cycles after the last sample; dump_ready low holds data, a newer dump overwrites and sets dump_overrun.
module integrator_dump_ctrl
    import integrator_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic [CNT_W-1:0] win_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             core_enable,
    output logic             core_strobe,
    output logic [IN_W-1:0]  core_sample,
    output logic             core_clr_n,
    input  logic [ACC_W-1:0] acc_in,
    input  logic             ovf_in,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [ACC_W-1:0] dump_data,
    output logic             dump_ovf,
    output logic             dump_overrun,
`ifdef INTEGRATOR_DUMP_SEQ_EN
    output logic [7:0]       dump_seq,
`endif
    output logic             busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             stop_q, stop_d;
    logic             s_ready_q, s_ready_d;
    logic             core_enable_q, core_enable_d;
    logic             core_strobe_q, core_strobe_d;
    logic [IN_W-1:0]  core_sample_q, core_sample_d;
    logic             core_clr_n_q, core_clr_n_d;
    logic             dump_valid_q, dump_valid_d;
    logic [ACC_W-1:0] dump_data_q, dump_data_d;
    logic             dump_ovf_q, dump_ovf_d;
    logic             dump_overrun_q, dump_overrun_d;
    logic             busy_q, busy_d;
    logic             dump_load;
`ifdef INTEGRATOR_DUMP_SEQ_EN
    logic [7:0]       seq_cnt_q, seq_cnt_d;
    logic [7:0]       dump_seq_q, dump_seq_d;
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        core_sample_d = core_sample_q;
        dump_load     = 1'b0;
        stop_d        = stop_q | (stop & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                len_d   = (win_len == '0) ? CNT_W'(1) : win_len;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // s_ready_q is high only in RUN, so it doubles as the handshake qualifier
                if (s_valid && s_ready_q) begin
                    core_sample_d = s_data;
                    state_d       = ST_STRB;
                end
            end
            ST_STRB: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == len_q) ? ST_SETTLE : ST_RUN;
            end
            ST_SETTLE: begin
                state_d = ST_DUMP;
            end
            ST_DUMP: begin
                dump_load = 1'b1;
                if (stop_q || stop) begin
                    stop_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d       = ST_IDLE;
            stop_d        = 1'b0;
            dump_load     = 1'b0;
            cnt_d         = cnt_q;
            core_sample_d = core_sample_q;
        end

        // A load in the same cycle as acceptance simply replaces the accepted word.
        dump_valid_d   = dump_valid_q & ~dump_ready;
        dump_overrun_d = dump_overrun_q | (dump_load & dump_valid_q & ~dump_ready);
        dump_data_d    = dump_data_q;
        dump_ovf_d     = dump_ovf_q;
        if (dump_load) begin
            dump_valid_d = 1'b1;
            dump_data_d  = acc_in;
            dump_ovf_d   = ovf_in;
        end

`ifdef INTEGRATOR_DUMP_SEQ_EN
        seq_cnt_d  = seq_cnt_q;
        dump_seq_d = dump_seq_q;
        if (dump_load) begin
            dump_seq_d = seq_cnt_q;
            seq_cnt_d  = seq_cnt_q + 8'd1;
        end
`endif

        s_ready_d     = (state_d == ST_RUN);
        core_enable_d = (state_d == ST_RUN) || (state_d == ST_STRB) ||
                        (state_d == ST_SETTLE) || (state_d == ST_DUMP);
        core_strobe_d = (state_d == ST_STRB);
        core_clr_n_d  = (state_d != ST_CLEAR);
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            len_q          <= '0;
            stop_q         <= 1'b0;
            s_ready_q      <= 1'b0;
            core_enable_q  <= 1'b0;
            core_strobe_q  <= 1'b0;
            core_sample_q  <= '0;
            core_clr_n_q   <= 1'b0;
            dump_valid_q   <= 1'b0;
            dump_data_q    <= '0;
            dump_ovf_q     <= 1'b0;
            dump_overrun_q <= 1'b0;
            busy_q         <= 1'b0;
`ifdef INTEGRATOR_DUMP_SEQ_EN
            seq_cnt_q      <= '0;
            dump_seq_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            stop_q         <= stop_d;
            s_ready_q      <= s_ready_d;
            core_enable_q  <= core_enable_d;
            core_strobe_q  <= core_strobe_d;
            core_sample_q  <= core_sample_d;
            core_clr_n_q   <= core_clr_n_d;
            dump_valid_q   <= dump_valid_d;
            dump_data_q    <= dump_data_d;
            dump_ovf_q     <= dump_ovf_d;
            dump_overrun_q <= dump_overrun_d;
            busy_q         <= busy_d;
`ifdef INTEGRATOR_DUMP_SEQ_EN
            seq_cnt_q      <= seq_cnt_d;
            dump_seq_q     <= dump_seq_d;
`endif
        end
    end

    assign s_ready      = s_ready_q;
    assign core_enable  = core_enable_q;
    assign core_strobe  = core_strobe_q;
    assign core_sample  = core_sample_q;
    assign core_clr_n   = core_clr_n_q;
    assign dump_valid   = dump_valid_q;
    assign dump_data    = dump_data_q;
    assign dump_ovf     = dump_ovf_q;
    assign dump_overrun = dump_overrun_q;
    assign busy         = busy_q;
`ifdef INTEGRATOR_DUMP_SEQ_EN
    assign dump_seq     = dump_seq_q;
`endif

endmodule

// File: tb/tb_integrator_dump_ctrl.sv
// Bench for integrator_dump_ctrl with a stand-in integrator core and a window-sum reference model.
module tb_integrator_dump_ctrl;

    localparam int IN_W  = 8;
    localparam int ACC_W = 16;
    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start = 1'b0, stop = 1'b0, abort = 1'b0;
    logic [CNT_W-1:0] win_len = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [IN_W-1:0]  s_data = '0;
    logic             core_enable, core_strobe, core_clr_n;
    logic [IN_W-1:0]  core_sample;
    logic [ACC_W-1:0] acc_in;
    logic             ovf_in;
    logic             dump_valid;
    logic             dump_ready = 1'b1;
    logic [ACC_W-1:0] dump_data;
    logic             dump_ovf, dump_overrun, busy;
`ifdef INTEGRATOR_DUMP_SEQ_EN
    logic [7:0]       dump_seq;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    integrator_dump_ctrl #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .abort(abort),
        .win_len(win_len), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_enable(core_enable), .core_strobe(core_strobe), .core_sample(core_sample),
        .core_clr_n(core_clr_n), .acc_in(acc_in), .ovf_in(ovf_in),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_ovf(dump_ovf), .dump_overrun(dump_overrun),
`ifdef INTEGRATOR_DUMP_SEQ_EN
        .dump_seq(dump_seq),
`endif
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    // Stand-in integrator core: rising-edge strobe detect, wrapping accumulator, sticky overflow.
    logic [ACC_W-1:0] core_acc;
    logic             core_ovf, core_strb_d;
    int               core_t;
    always @(posedge clk) begin
        core_strb_d <= core_strobe;
        if (!core_clr_n) begin
            core_acc <= '0;
            core_ovf <= 1'b0;
        end else if (core_enable && core_strobe && !core_strb_d) begin
            core_t = int'($signed(core_acc)) + int'($signed(core_sample));
            core_acc <= core_t[ACC_W-1:0];
            if (core_t > 32767 || core_t < -32768) core_ovf <= 1'b1;
        end
    end
    assign acc_in = core_acc;
    assign ovf_in = core_ovf;

    // Reference: group accepted samples into windows, sum them, and expect the
    // result in the dump register 3 edges after the closing handshake.
    int               cyc, win_cnt, win_acc, pend_at;
    bit               win_ovf, pend, pend_ovf, m_load;
    logic [ACC_W-1:0] pend_data, m_data;
    bit               m_valid, m_ovf, m_overrun;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; win_cnt = 0; win_acc = 0; win_ovf = 0;
            pend = 0; pend_at = 0; pend_data = '0; pend_ovf = 0;
            m_valid = 0; m_ovf = 0; m_overrun = 0; m_data = '0;
        end else begin
            cyc++;
            m_load = pend && (pend_at == cyc) && !abort;
            if (abort || m_load) pend = 0;
            if (m_load) begin
                m_overrun = m_overrun | (m_valid && !dump_ready);
                m_valid   = 1;
                m_data    = pend_data;
                m_ovf     = pend_ovf;
            end else if (dump_ready) begin
                m_valid = 0;
            end
            if (abort) begin
                win_cnt = 0; win_acc = 0; win_ovf = 0;
            end else if (s_valid && s_ready) begin
                win_acc += int'($signed(s_data));
                if (win_acc > 32767) begin win_acc -= 65536; win_ovf = 1; end
                else if (win_acc < -32768) begin win_acc += 65536; win_ovf = 1; end
                win_cnt++;
                if (win_cnt == ((win_len == 0) ? 1 : int'(win_len))) begin
                    pend = 1; pend_at = cyc + 3;
                    pend_data = win_acc[ACC_W-1:0]; pend_ovf = win_ovf;
                    win_cnt = 0; win_acc = 0; win_ovf = 0;
                end
            end
        end
    end

    logic [ACC_W:0] got_q[$];
    always @(posedge clk) begin
        if (rst_n === 1'b1 && dump_valid && dump_ready) got_q.push_back({dump_ovf, dump_data});
    end

    logic strb_prev_n = 1'b0;
    int   strb_cnt = 0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("dump_valid", 32'(dump_valid), 32'(m_valid));
            if (m_valid) begin
                check("dump_data", 32'(dump_data), 32'(m_data));
                check("dump_ovf", 32'(dump_ovf), 32'(m_ovf));
            end
            check("dump_overrun", 32'(dump_overrun), 32'(m_overrun));
            if (core_strobe) begin
                check("strobe_gap", 32'(strb_prev_n), 32'd0);
                check("strobe_enable", 32'(core_enable), 32'd1);
            end
            if (s_ready) check("ready_busy", 32'(busy), 32'd1);
        end
        strb_prev_n = core_strobe;
        strb_cnt += int'(core_strobe);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go_idle();
        abort = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        got_q.delete();
    endtask

    task automatic kick(input int len);
        win_len = CNT_W'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the sample was taken.
    task automatic send(input int x);
        s_valid = 1'b1;
        s_data  = IN_W'(x);
        for (int i = 0; i < 200 && !s_ready; i++) @(negedge clk);
        check("send_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 2000 && got_q.size() < n; i++) @(negedge clk);
        check("dump_count", 32'(got_q.size()), 32'(n));
    endtask

    function automatic logic [31:0] got_word(input int i);
        return (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
    endfunction

    int n0, sr;
    initial begin
        rst_n = 1'b0;
        tick(3);
        check("rst_outputs", 32'({s_ready, core_enable, core_strobe, core_clr_n, dump_valid,
                                  dump_ovf, dump_overrun, busy}), 32'd0);
        check("rst_data", 32'({dump_data, core_sample}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("clr_n_release", 32'(core_clr_n), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Basic window: 10+20-5+3
        go_idle();
        strb_cnt = 0;
        kick(4);
        send(10); send(20); send(-5); send(3);
        s_valid = 1'b0;
        wait_got(1);
        check("basic_sum", got_word(0), 32'd28);
        check("strobe_pulses", 32'(strb_cnt), 32'd4);

        // Repeat windows of 7+7, core cleared each time
        go_idle();
        kick(2);
        for (int i = 0; i < 6; i++) send(7);
        s_valid = 1'b0;
        wait_got(3);
        for (int i = 0; i < 3; i++) check("repeat_sum", got_word(i), 32'd14);
        check("no_overrun_ready_high", 32'(dump_overrun), 32'd0);

        // Backpressure and overrun
        go_idle();
        dump_ready = 1'b0;
        kick(1);
        send(5);
        s_valid = 1'b0;
        for (int i = 0; i < 50 && !dump_valid; i++) @(negedge clk);
        check("first_dump_valid", 32'(dump_valid), 32'd1);
        check("held_data", 32'(dump_data), 32'd5);
        send(9);
        s_valid = 1'b0;
        tick(6);
        check("overrun_data", 32'(dump_data), 32'd9);
        check("overrun_flag", 32'(dump_overrun), 32'd1);
        dump_ready = 1'b1;
        tick(1);
        check("valid_falls", 32'(dump_valid), 32'd0);

        // Graceful stop
        go_idle();
        kick(3);
        send(1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        send(2); send(3);
        s_valid = 1'b0;
        wait_got(1);
        check("stop_sum", got_word(0), 32'd6);
        tick(3);
        check("stop_busy", 32'(busy), 32'd0);
        sr = 0;
        repeat (10) begin @(negedge clk); sr += int'(s_ready); end
        check("stop_no_ready", 32'(sr), 32'd0);

        // Abort mid-window then a fresh window
        go_idle();
        kick(8);
        send(1); send(2); send(3);
        s_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_enable", 32'(core_enable), 32'd0);
        check("abort_ready", 32'(s_ready), 32'd0);
        n0 = got_q.size();
        tick(10);
        check("abort_no_dump", 32'(got_q.size()), 32'(n0));
        kick(8);
        for (int i = 10; i < 18; i++) send(i);
        s_valid = 1'b0;
        wait_got(1);
        check("abort_fresh_sum", got_word(0), 32'd108);

        // Overflow: 300 x 127 = 38100 wraps to 0x94D4 with the flag set
        go_idle();
        kick(300);
        for (int i = 0; i < 300; i++) send(127);
        s_valid = 1'b0;
        wait_got(1);
        check("ovf_sum", got_word(0), 32'h1_94D4);

        // Async reset mid-RUN, then win_len 0 acts as 1
        go_idle();
        kick(8);
        send(5);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", 32'({s_ready, core_enable, core_strobe, core_clr_n, dump_valid,
                                   dump_ovf, dump_overrun, busy}), 32'd0);
        check("arst_data", 32'({dump_data, core_sample}), 32'd0);
        tick(2);
        rst_n = 1'b1;
        #1;
        check("arst_clr_held", 32'(core_clr_n), 32'd0);
        @(posedge clk); #1;
        check("arst_clr_release", 32'(core_clr_n), 32'd1);
        check("arst_idle", 32'(busy), 32'd0);
        @(negedge clk);
        got_q.delete();
        kick(0);
        send(4); send(6);
        s_valid = 1'b0;
        wait_got(2);
        check("len0_first", got_word(0), 32'd4);
        check("len0_second", got_word(1), 32'd6);

        // Randomized traffic with backpressure, stops and aborts
        for (int ph = 0; ph < 3; ph++) begin
            go_idle();
            win_len = CNT_W'($urandom_range(0, 5));
            start = 1'b1;
            for (int c = 0; c < 2500; c++) begin
                @(negedge clk);
                s_valid    = ($urandom_range(0, 3) != 0);
                s_data     = IN_W'($urandom);
                dump_ready = ($urandom_range(0, 3) != 0);
                abort      = ($urandom_range(0, 99) == 0);
                stop       = ($urandom_range(0, 60) == 0);
            end
            dump_ready = 1'b1;
        end
        go_idle();
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
